warp_fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the warp instruction FIFO. On a kernel launch it streams `length` 32-bit instruction words from memory, starting at a word-aligned base address, over a valid/ready request port. It forwards each response straight into the FIFO push port. Credit-based flow control against the FIFO's free-slot count guarantees no response is ever dropped or pushed into a full FIFO.

---
 rtl/warp_pkg.sv | 20 ++
 rtl/warp_fetch_credit.sv | 47 ++++
 rtl/warp_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/warp_pkg.sv
// Shared types and defaults for the warp instruction fetch path.
// No logic; constants only.
// No flow control; referenced by the fetch unit and its credit tracker.
package warp_pkg;

    localparam int ADDR_WIDTH                    = 32;
    localparam int FIFO_DEPTH                    = 16;
    localparam int FETCH_MAX_OUTSTANDING_DEFAULT = 4;
    localparam int FETCH_TIMEOUT_DEFAULT         = 1024;
    localparam int WORD_BYTES                    = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        ERR
    } fetch_state_e;

endpackage

// File: rtl/warp_fetch_credit.sv
// Outstanding-read counter and issue permit against FIFO credit and MAX_OUTSTANDING.
// Latency: permit is combinational from the registered count; count updates next edge.
// Backpressure: permit drops whenever another read could overrun the FIFO or the read limit.
module warp_fetch_credit import warp_pkg::*; #(
    parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING_DEFAULT,
    parameter int FREE_W          = 5,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic              i_resp,
    input  logic [FREE_W-1:0] i_fifo_free,
    output logic [CNT_W-1:0]  o_outstanding,
    output logic              o_permit
);

    localparam int CMP_W = (CNT_W > FREE_W) ? CNT_W : FREE_W;

    logic [CNT_W-1:0] r_outstanding;
    logic             w_dec;
    logic [CMP_W-1:0] w_out_ext;
    logic [CMP_W-1:0] w_free_ext;
    logic [CMP_W-1:0] w_max_ext;

    // A stray response with nothing outstanding must not wrap the counter.
    assign w_dec      = i_resp && (r_outstanding != '0);
    assign w_out_ext  = CMP_W'(r_outstanding);
    assign w_free_ext = CMP_W'(i_fifo_free);
    assign w_max_ext  = CMP_W'(MAX_OUTSTANDING);

    assign o_permit      = (w_out_ext < w_free_ext) && (w_out_ext < w_max_ext);
    assign o_outstanding = r_outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({i_accept, w_dec})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: rtl/warp_fetch_unit.sv
// Streams `length` instruction words from memory into the warp FIFO; watchdog under WARP_FETCH_TIMEOUT_EN.
// Latency: response-to-push is zero cycles (combinational pass-through).
// Backpressure: reads issue only while outstanding < fifo_free, so a response is never refused.
module warp_fetch_unit #(
    parameter int ADDR_WIDTH      = warp_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH      = warp_pkg::FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = warp_pkg::FETCH_MAX_OUTSTANDING_DEFAULT,
    parameter int TIMEOUT_CYCLES  = warp_pkg::FETCH_TIMEOUT_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [15:0]                        length,
    input  logic                               abort,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    input  logic                               mem_resp_valid,
    output logic                               mem_resp_ready,
    input  logic [31:0]                        mem_resp_data,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_free,
    output logic                               fifo_push,
    output logic [31:0]                        fifo_data,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [15:0]                        words_pushed
);

    import warp_pkg::*;

    localparam int FREE_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ALIGN_W = $clog2(WORD_BYTES);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max
        $error("MAX_OUTSTANDING must be at least 1");
    end

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_length;
    logic [15:0]           r_issued;
    logic [15:0]           r_words;
    logic                  r_discard;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_req_hs;
    logic                  w_resp_hs;
    logic                  w_permit;
    logic [CNT_W-1:0]      w_outstanding;
    logic                  w_fetch_last;
    logic                  w_timeout;

    assign mem_req_valid  = (r_state == FETCH) && (r_issued < r_length) && w_permit;
    assign mem_req_addr   = r_addr;
    assign mem_resp_ready = (r_state == FETCH) || (r_state == DRAIN);
    assign w_req_hs       = mem_req_valid && mem_req_ready;
    assign w_resp_hs      = mem_resp_valid && mem_resp_ready;
    assign fifo_push      = w_resp_hs && !r_discard;
    assign fifo_data      = mem_resp_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign words_pushed   = r_words;

    // All reads issued and the last one (if any) is answered this cycle.
    assign w_fetch_last = (r_issued == r_length) && (w_outstanding == CNT_W'(w_resp_hs));

    warp_fetch_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .FREE_W          (FREE_W)
    ) u_credit (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_accept      (w_req_hs),
        .i_resp        (w_resp_hs),
        .i_fifo_free   (fifo_free),
        .o_outstanding (w_outstanding),
        .o_permit      (w_permit)
    );

`ifdef WARP_FETCH_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_timeout = (r_state == FETCH) && (w_outstanding != '0) && !w_resp_hs &&
                       (r_wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state != FETCH || w_resp_hs || w_outstanding == '0) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_length  <= '0;
            r_issued  <= '0;
            r_words   <= '0;
            r_discard <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (base_addr[ALIGN_W-1:0] != '0) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else if (length == 16'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= FETCH;
                            r_addr    <= base_addr;
                            r_length  <= length;
                            r_issued  <= '0;
                            r_words   <= '0;
                            r_discard <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (w_req_hs) begin
                        r_issued <= r_issued + 16'd1;
                        r_addr   <= r_addr + ADDR_WIDTH'(WORD_BYTES);
                    end
                    if (fifo_push) begin
                        r_words <= r_words + 16'd1;
                    end
                    // Abort wins over a same-cycle completion: the kernel is reported as failed.
                    if (abort || w_timeout) begin
                        r_state   <= DRAIN;
                        r_discard <= 1'b1;
                    end else if (w_fetch_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_outstanding == '0) begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
